ans_histogram: RTL and testbench
================================

# ans_histogram

Symbol-frequency collector that sits directly upstream of the ANS loader in the `ans` datapath. It accepts a block of 4-bit symbols over a valid/ready stream, counts occurrences per symbol, then emits the 16-entry count table as a nibble stream in the exact order the loader consumes it (symbol 0 first). This lets the host derive the coding table from real data instead of computing counts off-chip. After the table is emitted, it clears itself for the next block.

## Interface
- `SYM_WIDTH`, 4, symbol width in bits
- `SYM_COUNT`, 16, number of distinct symbols (2^SYM_WIDTH)
- `CNT_WIDTH`, 4, width of each emitted count
- `BLOCK_LEN`, 15, symbols per block before automatic emit; legal range 1..255
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in`  in  SYM_WIDTH  input symbol
- `in_vld`  in  1  input symbol valid
- `in_rdy`  out  1  block can accept a symbol
- `flush`  in  1  end the current block early; sampled only in COLLECT
- `out`  out  CNT_WIDTH  count for symbol `idx`
- `out_vld`  out  1  `out` holds a valid count
- `out_rdy`  in  1  downstream (loader) accepts count
- `busy`  out  1  high in EMIT

## Operation
- Storage: 16 × CNT_WIDTH counters `hist[0..15]`, 8-bit block counter `n`, 4-bit emit index `idx`, 1-bit state.
- States: COLLECT (after reset) and EMIT.
- COLLECT: `in_rdy`=1, `out_vld`=0. Accept = `in_vld & in_rdy`. On accept: `hist[in]` += 1, saturating at 2^CNT_WIDTH−1, and `n` += 1.
- COLLECT→EMIT when (accept and `n`+1 == BLOCK_LEN) or (`flush` and (`n` != 0 or accept)). Flush and accept in the same cycle: count the symbol first, then go to EMIT.
- `flush` with `n`==0 and no accept is ignored. No empty table is emitted.
- EMIT: `in_rdy`=0, so `in_vld` is ignored and nothing is counted. `out_vld`=1, `out`=`hist[idx]`, `idx` starts at 0. On `out_vld & out_rdy`, `idx` += 1.
- The handshake at `idx`==15 is the last. On that cycle: all `hist` entries←0, `n`←0, `idx`←0, state←COLLECT.
- `out` is driven from registered state only; no combinational path from `in` to `out`.
- Saturation can only occur when BLOCK_LEN > 15. Saturated counters hold at 15.
- Reset (any time, including mid-EMIT): state=COLLECT, all `hist`=0, `n`=0, `idx`=0. The partial table is discarded.

## Timing
- Reset values: `in_rdy`=1, `out_vld`=0, `out`=0, `busy`=0.
- Throughput in COLLECT is 1 symbol/cycle.
- `out_vld` rises on the cycle after the final accept or qualifying flush.
- Emit takes 16 handshakes. With `out_rdy` held high, that is exactly 16 cycles.
- `out`/`out_vld` stay stable while `out_vld & !out_rdy`.
- `in_rdy` returns to 1 on the cycle after the 16th output handshake. The block can accept a symbol on that same cycle.
- Minimum block turnaround with no stalls: BLOCK_LEN + 16 cycles.

## Test plan
- Fifteen symbols `3`, back-to-back → after the last accept, 16 outputs: `hist[3]`=15, all others 0. `in_rdy` low for exactly 16 cycles.
- Symbols 0..14 in order → outputs 1 for symbols 0..14 and 0 for symbol 15. A second identical block gives the same result, confirming the clear.
- Five symbols `7`, then `flush` together with a sixth symbol `2` → `hist[7]`=5, `hist[2]`=1, others 0. `flush` with `n`=0 and `in_vld`=0 → no state change.
- EMIT with `out_rdy` toggled pseudo-randomly, and `in_vld`=1 with `in`=5 throughout → `out` held stable during stalls, 16 outputs in order, no symbol counted during EMIT.
- Reset asserted after 8 of 16 outputs → `out_vld` drops immediately. Next block of fifteen `0`s emits `hist[0]`=15 only.
- BLOCK_LEN=20 with twenty symbols `9` → `hist[9]` saturates at 15, all others 0.

Source files
------------

// File: rtl/ans_histogram.sv
// Per-block symbol histogram for the ANS loader. Counts 4-bit symbols during
// COLLECT, then streams the 16 counts (symbol 0 first) during EMIT.
module ans_histogram #(
  parameter int SYM_WIDTH = 4,
  parameter int SYM_COUNT = 16,
  parameter int CNT_WIDTH = 4,
  parameter int BLOCK_LEN = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SYM_WIDTH-1:0] in,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic                 flush,
  output logic [CNT_WIDTH-1:0] out,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 busy
);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_EMIT    = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [7:0]           LAST_N   = 8'(BLOCK_LEN);
  localparam logic [SYM_WIDTH-1:0] LAST_IDX = SYM_WIDTH'(SYM_COUNT - 1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_hist [SYM_COUNT];
  logic [7:0]           r_n;
  logic [SYM_WIDTH-1:0] r_idx;

  logic       w_accept;
  logic [7:0] w_n_next;
  logic       w_to_emit;
  logic       w_out_hs;
  logic       w_last_out;

  assign w_accept   = in_vld && (r_state == S_COLLECT);
  assign w_n_next   = r_n + 8'd1;
  // A same-cycle accept makes the block non-empty, so a flush then still emits.
  assign w_to_emit  = (r_state == S_COLLECT) &&
                      ((w_accept && (w_n_next == LAST_N)) ||
                       (flush && ((r_n != 8'd0) || w_accept)));
  assign w_out_hs   = (r_state == S_EMIT) && out_rdy;
  assign w_last_out = w_out_hs && (r_idx == LAST_IDX);

  // Outputs decode only the registered state, so nothing from `in` reaches `out`.
  assign in_rdy  = (r_state == S_COLLECT);
  assign out_vld = (r_state == S_EMIT);
  assign busy    = (r_state == S_EMIT);
  assign out     = (r_state == S_EMIT) ? r_hist[r_idx] : '0;

  // NOTE: the counter array is reset explicitly because reset must discard a
  // partially collected or partially emitted table, not just the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
      r_n     <= 8'd0;
      r_idx   <= '0;
      for (int i = 0; i < SYM_COUNT; i++) r_hist[i] <= '0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            if (r_hist[in] != CNT_MAX) r_hist[in] <= r_hist[in] + 1'b1;
            r_n <= w_n_next;
          end
          if (w_to_emit) begin
            r_state <= S_EMIT;
            r_idx   <= '0;
          end
        end
        S_EMIT: begin
          if (w_last_out) begin
            r_state <= S_COLLECT;
            r_n     <= 8'd0;
            r_idx   <= '0;
            for (int i = 0; i < SYM_COUNT; i++) r_hist[i] <= '0;
          end else if (w_out_hs) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_ans_histogram.sv
// Bench for ans_histogram: two instances (BLOCK_LEN 15 and 20) share stimulus
// and are checked every cycle against a per-instance histogram model.
module tb_ans_histogram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sym = 4'd0;
  logic       in_vld = 1'b0;
  logic       flush = 1'b0;
  logic       out_rdy = 1'b1;

  logic       in_rdy0, out_vld0, busy0;
  logic [3:0] out0;
  logic       in_rdy1, out_vld1, busy1;
  logic [3:0] out1;

  int total = 0;
  int bad   = 0;

  // model state, index 0 = BLOCK_LEN 15, index 1 = BLOCK_LEN 20
  int m_hist [2][16];
  int m_n    [2];
  bit m_emit [2];
  int m_idx  [2];
  int blk    [2] = '{15, 20};

  int cap0[$];
  int cap1[$];

  always #5 clk = ~clk;

  ans_histogram #(.BLOCK_LEN(15)) dut0 (
    .clk(clk), .rst(rst), .in(sym), .in_vld(in_vld), .in_rdy(in_rdy0),
    .flush(flush), .out(out0), .out_vld(out_vld0), .out_rdy(out_rdy), .busy(busy0)
  );

  ans_histogram #(.BLOCK_LEN(20)) dut1 (
    .clk(clk), .rst(rst), .in(sym), .in_vld(in_vld), .in_rdy(in_rdy1),
    .flush(flush), .out(out1), .out_vld(out_vld1), .out_rdy(out_rdy), .busy(busy1)
  );

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: a block is a bag of symbols; once it is full (or flushed while
  // non-empty) its 16 saturated counts are handed out one per handshake.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int s = 0; s < 16; s++) m_hist[k][s] = 0;
        m_n[k] = 0; m_emit[k] = 1'b0; m_idx[k] = 0;
      end else if (!m_emit[k]) begin
        if (in_vld) begin
          if (m_hist[k][sym] < 15) m_hist[k][sym]++;
          m_n[k]++;
        end
        if ((in_vld && m_n[k] == blk[k]) || (flush && m_n[k] != 0)) begin
          m_emit[k] = 1'b1;
          m_idx[k]  = 0;
        end
      end else if (out_rdy) begin
        m_idx[k]++;
        if (m_idx[k] == 16) begin
          for (int s = 0; s < 16; s++) m_hist[k][s] = 0;
          m_n[k] = 0; m_emit[k] = 1'b0; m_idx[k] = 0;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge; log handshaken counts.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int exp_out;
      exp_out = m_emit[k] ? m_hist[k][m_idx[k]] : 0;
      check($sformatf("in_rdy[%0d]", k),  int'(k == 0 ? in_rdy0 : in_rdy1), int'(!m_emit[k]));
      check($sformatf("out_vld[%0d]", k), int'(k == 0 ? out_vld0 : out_vld1), int'(m_emit[k]));
      check($sformatf("busy[%0d]", k),    int'(k == 0 ? busy0 : busy1), int'(m_emit[k]));
      check($sformatf("out[%0d]", k),     int'(k == 0 ? out0 : out1), exp_out);
    end
    if (!rst && out_rdy && out_vld0) cap0.push_back(int'(out0));
    if (!rst && out_rdy && out_vld1) cap1.push_back(int'(out1));
  end

  task automatic cyc(input bit v, input logic [3:0] s, input bit f, input bit r);
    in_vld = v; sym = s; flush = f; out_rdy = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    rst = 1'b0;
    cyc(0, 0, 0, 1);
    cap0.delete();
    cap1.delete();
  endtask

  // Run until the chosen instance has delivered 16 counts, within a budget.
  task automatic drain(input bit which, input bit rand_rdy, input bit v, input logic [3:0] s);
    int n;
    n = 0;
    while (((which == 0) ? cap0.size() : cap1.size()) < 16 && n < 300) begin
      cyc(v, s, 0, rand_rdy ? bit'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    if (n >= 300) check("drain_timeout", n, 0);
  endtask

  task automatic check_table(input string name, input bit which, input int exp[16]);
    for (int i = 0; i < 16; i++) begin
      int got;
      got = -1;
      if (which == 0 && i < cap0.size()) got = cap0[i];
      if (which == 1 && i < cap1.size()) got = cap1[i];
      check($sformatf("%s[%0d]", name, i), got, exp[i]);
    end
  endtask

  initial begin
    int exp_t[16];
    int low;

    rst = 1'b1;
    #1;
    check("reset_in_rdy", int'(in_rdy0), 1);
    check("reset_out_vld", int'(out_vld0), 0);
    check("reset_out", int'(out0), 0);
    check("reset_busy", int'(busy0), 0);
    do_reset();

    // fifteen 3s back to back
    for (int i = 0; i < 15; i++) cyc(1, 4'd3, 0, 1);
    low = 0;
    for (int i = 0; i < 40; i++) begin
      if (in_rdy0) break;
      low++;
      cyc(0, 0, 0, 1);
    end
    check("in_rdy_low_cycles", low, 16);
    for (int i = 0; i < 16; i++) exp_t[i] = (i == 3) ? 15 : 0;
    check_table("all_threes", 0, exp_t);

    // symbols 0..14, twice, to show the table clears between blocks
    do_reset();
    for (int b = 0; b < 2; b++) begin
      cap0.delete();
      for (int i = 0; i < 15; i++) cyc(1, 4'(i), 0, 1);
      drain(0, 0, 0, 0);
      for (int i = 0; i < 16; i++) exp_t[i] = (i < 15) ? 1 : 0;
      check_table($sformatf("ramp_blk%0d", b), 0, exp_t);
    end

    // idle flush is ignored, then five 7s and a flush carrying a 2
    do_reset();
    cyc(0, 0, 1, 1);
    check("idle_flush_in_rdy", int'(in_rdy0), 1);
    check("idle_flush_out_vld", int'(out_vld0), 0);
    for (int i = 0; i < 5; i++) cyc(1, 4'd7, 0, 1);
    cyc(1, 4'd2, 1, 1);
    check("flush_out_vld", int'(out_vld0), 1);
    drain(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) exp_t[i] = (i == 7) ? 5 : (i == 2) ? 1 : 0;
    check_table("flush_tbl", 0, exp_t);

    // stalled emit with in_vld=1, in=5 held throughout
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1, 4'(i % 3), 0, 1);
    drain(0, 1, 1, 4'd5);
    for (int i = 0; i < 16; i++) exp_t[i] = (i < 3) ? 5 : 0;
    check_table("stall_tbl", 0, exp_t);

    // reset after 8 of 16 outputs, then fifteen 0s
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1, 4'd0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
    rst = 1'b1;
    #1;
    check("midemit_rst_out_vld", int'(out_vld0), 0);
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1, 4'd0, 0, 1);
    drain(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) exp_t[i] = (i == 0) ? 15 : 0;
    check_table("post_rst_tbl", 0, exp_t);

    // BLOCK_LEN 20 instance: twenty 9s saturate at 15
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 4'd9, 0, 1);
    drain(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) exp_t[i] = (i == 9) ? 15 : 0;
    check_table("sat_tbl", 1, exp_t);

    // randomized traffic, rare flushes and resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) rst = 1'b1;
      else rst = 1'b0;
      cyc(bit'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
          bit'($urandom_range(0, 29) == 0), bit'($urandom_range(0, 3) != 0));
    end
    rst = 1'b0;
    cyc(0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
